// File: rtl/bk_mem_pkg.sv
// bk_mem_pkg: shared FSM states, BK window bases and page geometry for the disk copy bridge
package bk_mem_pkg;
    typedef enum logic [2:0] {S_IDLE, S_XLATE, S_REQ, S_WAIT, S_ABORT} state_t;
    localparam logic [15:0] WIN0_BASE = 16'o000000;
    localparam logic [15:0] WIN1_BASE = 16'o040000;
    localparam logic [15:0] WIN2_BASE = 16'o100000;
    localparam logic [15:0] WIN3_BASE = 16'o140000;
    localparam int PAGE_SIZE = 16384;
    localparam int PAGE_BITS = $clog2(PAGE_SIZE);
    function automatic logic [1:0] win_idx(input logic [15:0] va);
        return va >= WIN3_BASE ? 2'd3 : va >= WIN2_BASE ? 2'd2 : va >= WIN1_BASE ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/bk_vaddr_map.sv
// bk_vaddr_map: maps a physical or 16-bit BK virtual address onto a word-aligned physical byte address
module bk_vaddr_map
    import bk_mem_pkg::*;
(
    input  logic        virt,
    input  logic [24:0] vaddr,
    input  logic [2:0]  page_win1,
    input  logic [2:0]  page_win2,
    output logic [24:0] paddr,
    output logic        valid
);
    logic [1:0] win;
    logic [2:0] page;
    logic       unused_bit0;
    assign unused_bit0 = vaddr[0];
    // window 0 is fixed page 0; window 3 is ROM/IO and has no RAM behind it
    always_comb begin
        win   = win_idx(vaddr[15:0]);
        page  = win == 2'd1 ? page_win1 : win == 2'd2 ? page_win2 : 3'd0;
        paddr = virt ? {8'd0, page, vaddr[PAGE_BITS-1:1], 1'b0} : {vaddr[24:1], 1'b0};
        valid = !virt || win != 2'd3;
    end
endmodule

// File: rtl/dsk_mem_bridge.sv
// dsk_mem_bridge: turns disk copy engine strobes into single req/ack memory accesses with timeout
module dsk_mem_bridge
    import bk_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dsk_copy,
    input  logic        dsk_copy_virt,
    input  logic [24:0] dsk_copy_addr,
    input  logic [15:0] dsk_copy_dout,
    input  logic        dsk_copy_we,
    input  logic        dsk_copy_rd,
    output logic [15:0] dsk_copy_din,
    input  logic [2:0]  page_win1,
    input  logic [2:0]  page_win2,
    output logic [24:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic          strobe_q;
    logic          copy_q;
    logic          we_l;
    logic          virt_l;
    logic [24:0]   addr_l;
    logic [15:0]   dout_l;
    logic [CW-1:0] cnt;
    logic [24:0]   paddr;
    logic          valid;
    logic          start;
    assign start = dsk_copy && (dsk_copy_rd || dsk_copy_we) && !strobe_q;
    assign busy  = state != S_IDLE;
    bk_vaddr_map u_map (
        .virt      (virt_l),
        .vaddr     (addr_l),
        .page_win1 (page_win1),
        .page_win2 (page_win2),
        .paddr     (paddr),
        .valid     (valid)
    );
    // access FSM; strobe history resets high so a level held through reset is not a new edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            strobe_q     <= 1'b1;
            copy_q       <= 1'b0;
            we_l         <= 1'b0;
            virt_l       <= 1'b0;
            addr_l       <= '0;
            dout_l       <= '0;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            dsk_copy_din <= '0;
            err          <= 1'b0;
        end else begin
            strobe_q <= dsk_copy_rd || dsk_copy_we;
            copy_q   <= dsk_copy;
            if (state != S_IDLE && !dsk_copy) begin
                state   <= S_IDLE;
                mem_req <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state  <= S_XLATE;
                        we_l   <= dsk_copy_we;
                        virt_l <= dsk_copy_virt;
                        addr_l <= dsk_copy_addr;
                        dout_l <= dsk_copy_dout;
                        if (!copy_q) err <= 1'b0;
                    end
                    S_XLATE: if (valid) begin
                        state     <= S_REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= paddr;
                        mem_we    <= we_l;
                        mem_wdata <= dout_l;
                    end else begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        if (!we_l) dsk_copy_din <= 16'h0000;
                    end
                    S_REQ, S_WAIT: if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        if (!mem_we) dsk_copy_din <= mem_rdata;
                    end else if (state == S_REQ) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state        <= S_ABORT;
                        mem_req      <= 1'b0;
                        err          <= 1'b1;
                        dsk_copy_din <= 16'hFFFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/dsk_mem_bridge.md
DSK_MEM_BRIDGE -- requirements
Module: dsk_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 SHALL have ports (name direction width meaning):
  clk_sys  in  1  the single system clock.
  reset_n  in  1  asynchronous active-low reset.
  dsk_copy  in  1  disk copy engine owns memory.
  dsk_copy_virt  in  1  address is a 16-bit BK virtual address.
  dsk_copy_addr  in  25  byte address, physical or virtual.
  dsk_copy_dout  in  16  write data from the engine.
  dsk_copy_we  in  1  write level, held for at least 2 cycles.
  dsk_copy_rd  in  1  read level, held for at least 2 cycles.
  dsk_copy_din  out  16  read data returned to the engine.
  page_win1  in  3  RAM page mapped at 040000-077777.
  page_win2  in  3  RAM page mapped at 100000-137777.
  mem_addr  out  25  physical byte address.
  mem_req  out  1  request level.
  mem_we  out  1  write qualifier.
  mem_wdata  out  16  write data.
  mem_ack  in  1  single-cycle completion pulse.
  mem_rdata  in  16  read data, valid when mem_ack is high.
  busy  out  1  an access is in flight.
  err  out  1  sticky fault flag.

Function
REQ-003 SHALL detect the start of an access on a rising edge of (dsk_copy_rd | dsk_copy_we) while dsk_copy=1; a write SHALL win when both rise together.
REQ-004 SHALL latch the address, data and direction on that edge; input changes afterwards SHALL NOT affect the access.
REQ-005 SHALL ignore the held levels, so a 2-cycle strobe SHALL cause exactly one memory access.
REQ-006 SHALL implement the states IDLE -> XLATE -> REQ -> WAIT -> IDLE, with an ABORT state reachable from WAIT.
REQ-007 SHALL translate a physical address (virt=0) to mem_addr = dsk_copy_addr with bit 0 cleared.
REQ-008 SHALL translate a virtual address (virt=1) by window, using bits [15:14]:
  00 -> page 0.
  01 -> page_win1.
  10 -> page_win2.
  In each case mem_addr = {page, addr[13:1], 1'b0} zero-extended to 25 bits.
REQ-009 SHALL treat a virtual window 11 (ROM/IO) as invalid: no mem_req, read data 16'h0000, write dropped, err set, back to IDLE after XLATE.
REQ-010 SHALL use only bits [15:0] for a virtual address; bits [24:16] SHALL be ignored.
REQ-011 SHALL assert mem_req on entry to REQ and hold it, together with mem_addr, mem_we and mem_wdata, stable until the mem_ack cycle.
REQ-012 SHALL drop mem_req in the cycle after mem_ack.
REQ-013 SHALL load dsk_copy_din from mem_rdata in the mem_ack cycle of a read; dsk_copy_din SHALL be visible from the next edge and hold until the next read completes.
REQ-014 SHALL NOT change dsk_copy_din on a write.
REQ-015 SHALL complete a read in 4 cycles from the start edge when mem_ack arrives on the first WAIT cycle, so that data is ready before the engine samples it.
REQ-016 SHALL count cycles in WAIT and go to ABORT when the count reaches TIMEOUT: mem_req dropped, err set, dsk_copy_din=16'hFFFF, then IDLE.
REQ-017 SHALL drop mem_req and return to IDLE next cycle when dsk_copy falls mid-access; err SHALL NOT be set and a late mem_ack SHALL be ignored.
REQ-018 SHALL ignore a new start edge while not in IDLE; no queuing SHALL occur.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL hold err sticky until reset, or until a start edge that occurs while dsk_copy has just risen (new copy session).

Reset
REQ-021 SHALL, on reset_n=0 at any time, asynchronously force state IDLE.
REQ-022 SHALL, on reset, drive mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dsk_copy_din=0, busy=0, err=0 and clear the timeout counter.
REQ-023 SHALL, for a reset mid-access, issue no further request after release and ignore any pending mem_ack.

Structure
REQ-024 SHALL place the state enumeration, the window base constants (000000, 040000, 100000, 140000) and the page size 16 KB in the shared package bk_mem_pkg.
REQ-025 SHALL implement the address translation (REQ-007..010) as the combinational sub-module bk_vaddr_map, with no other sub-modules.

Verification
REQ-026 SHALL cover a virtual read: virt=1, addr=16'o040002, page_win1=3, mem_ack on the first WAIT cycle -> mem_addr=25'h00C002, dsk_copy_din=mem_rdata=16'h1234 within 4 cycles, exactly one mem_req.
REQ-027 SHALL cover a physical write: virt=0, addr=25'h120001, dout=16'hA5A5 -> mem_addr=25'h120000, mem_we=1, mem_wdata=16'hA5A5, dsk_copy_din unchanged.
REQ-028 SHALL cover a ROM window: virt=1, addr=16'o177132, read -> no mem_req, dsk_copy_din=0, err=1.
REQ-029 SHALL cover a timeout: mem_ack never asserted -> mem_req dropped after 255 WAIT cycles, err=1, dsk_copy_din=16'hFFFF, busy=0.
REQ-030 SHALL cover an abort: dsk_copy dropped in WAIT, then mem_ack pulsed -> IDLE, err=0, dsk_copy_din unchanged.
REQ-031 SHALL cover asynchronous reset: reset_n pulsed low mid-WAIT -> all outputs 0 immediately and no request after release.
